// File: rtl/ccff_config_loader.sv
// Configuration-chain loader: serializes a byte stream MSB-first onto ccff_head with a registered prog_clk.
// Define CCFF_CONFIG_LOADER_PARITY_EN to add the trailer-byte parity check (CHECK/ERROR path, cfg_err).
module ccff_config_loader #(
  parameter int BITSTREAM_LENGTH  = 1258,
  parameter int RESET_HOLD_CYCLES = 4,
  parameter int CNT_W             = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       byte_data,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             ccff_head,
  output logic             prog_clk,
  output logic             prog_reset,
  output logic             config_done,
  output logic             greset,
  output logic             busy,
  output logic [CNT_W-1:0] bit_count,
  output logic             cfg_err
);

  localparam int HOLD_W = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  LEN_C       = CNT_W'(BITSTREAM_LENGTH);
  localparam logic [HOLD_W-1:0] HOLD_LAST_C = HOLD_W'(RESET_HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SHIFT_LO = 3'd1,
    S_SHIFT_HI = 3'd2,
    S_CHECK    = 3'd3,
    S_HOLD     = 3'd4,
    S_DONE     = 3'd5,
    S_ERROR    = 3'd6
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        sr_q, sr_d;
  logic [3:0]        sr_cnt_q, sr_cnt_d;
  logic [CNT_W-1:0]  bit_count_q, bit_count_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              head_q, head_d;
  logic              byte_ready_q, byte_ready_d;
  logic              prog_clk_q, prog_clk_d;
  logic              prog_reset_q, prog_reset_d;
  logic              config_done_q, config_done_d;
  logic              greset_q, greset_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  bits_rem_s;
  logic [3:0]        load_cnt_s;
  logic              hs_s;
`ifdef CCFF_CONFIG_LOADER_PARITY_EN
  logic              parity_q, parity_d;
  logic              cfg_err_q, cfg_err_d;
`endif

  // The final byte only carries the bits still owed to the chain.
  assign bits_rem_s = LEN_C - bit_count_q;
  assign load_cnt_s = (bits_rem_s >= CNT_W'(8)) ? 4'd8 : bits_rem_s[3:0];
  assign hs_s       = byte_valid & byte_ready_q;

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    sr_cnt_d    = sr_cnt_q;
    bit_count_d = bit_count_q;
    hold_cnt_d  = hold_cnt_q;
    head_d      = head_q;
`ifdef CCFF_CONFIG_LOADER_PARITY_EN
    parity_d    = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_SHIFT_LO;
          bit_count_d = '0;
          sr_cnt_d    = 4'd0;
`ifdef CCFF_CONFIG_LOADER_PARITY_EN
          parity_d    = 1'b0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT_LO: begin
        if (sr_cnt_q == 4'd0) begin
          if (hs_s) begin
            sr_d     = byte_data;
            sr_cnt_d = load_cnt_s;
            head_d   = byte_data[7];
          end else begin
            state_d = S_SHIFT_LO;
          end
        end else begin
          state_d     = S_SHIFT_HI;
          head_d      = sr_q[7];
          bit_count_d = bit_count_q + CNT_W'(1);
          sr_d        = {sr_q[6:0], 1'b0};
          sr_cnt_d    = sr_cnt_q - 4'd1;
`ifdef CCFF_CONFIG_LOADER_PARITY_EN
          parity_d    = parity_q ^ sr_q[7];
`endif
        end
      end
      S_SHIFT_HI: begin
        if (bit_count_q == LEN_C) begin
          hold_cnt_d = '0;
`ifdef CCFF_CONFIG_LOADER_PARITY_EN
          state_d    = S_CHECK;
`else
          state_d    = S_HOLD;
`endif
        end else begin
          state_d = S_SHIFT_LO;
          // Present the next bit while prog_clk is low; keep the old value on underrun.
          if (sr_cnt_q != 4'd0) begin
            head_d = sr_q[7];
          end else begin
            head_d = head_q;
          end
        end
      end
`ifdef CCFF_CONFIG_LOADER_PARITY_EN
      S_CHECK: begin
        if (hs_s) begin
          if (byte_data[0] == parity_q) begin
            state_d    = S_HOLD;
            hold_cnt_d = '0;
          end else begin
            state_d = S_ERROR;
          end
        end else begin
          state_d = S_CHECK;
        end
      end
`endif
      S_HOLD: begin
        if (hold_cnt_q == HOLD_LAST_C) begin
          state_d = S_DONE;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      S_DONE:  state_d = S_DONE;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase

    // Outputs are decoded from the next state so every port comes straight from a flop.
    byte_ready_d  = ((state_d == S_SHIFT_LO) && (sr_cnt_d == 4'd0)) || (state_d == S_CHECK);
    prog_clk_d    = (state_d == S_SHIFT_HI);
    prog_reset_d  = (state_d == S_IDLE);
    config_done_d = (state_d == S_HOLD) || (state_d == S_DONE);
    greset_d      = (state_d != S_DONE);
    busy_d        = (state_d != S_IDLE) && (state_d != S_DONE) && (state_d != S_ERROR);
`ifdef CCFF_CONFIG_LOADER_PARITY_EN
    cfg_err_d     = (state_d == S_ERROR);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      sr_q          <= 8'h00;
      sr_cnt_q      <= 4'd0;
      bit_count_q   <= '0;
      hold_cnt_q    <= '0;
      head_q        <= 1'b0;
      byte_ready_q  <= 1'b0;
      prog_clk_q    <= 1'b0;
      prog_reset_q  <= 1'b1;
      config_done_q <= 1'b0;
      greset_q      <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      sr_q          <= sr_d;
      sr_cnt_q      <= sr_cnt_d;
      bit_count_q   <= bit_count_d;
      hold_cnt_q    <= hold_cnt_d;
      head_q        <= head_d;
      byte_ready_q  <= byte_ready_d;
      prog_clk_q    <= prog_clk_d;
      prog_reset_q  <= prog_reset_d;
      config_done_q <= config_done_d;
      greset_q      <= greset_d;
      busy_q        <= busy_d;
    end
  end

`ifdef CCFF_CONFIG_LOADER_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_q  <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      parity_q  <= parity_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg_err = cfg_err_q;
`else
  assign cfg_err = 1'b0;
`endif

  assign byte_ready  = byte_ready_q;
  assign ccff_head   = head_q;
  assign prog_clk    = prog_clk_q;
  assign prog_reset  = prog_reset_q;
  assign config_done = config_done_q;
  assign greset      = greset_q;
  assign busy        = busy_q;
  assign bit_count   = bit_count_q;

endmodule

// File: tb/tb_ccff_config_loader.sv
// Bench for ccff_config_loader: a 10-bit instance driven from a vector table and a full-length 1258-bit instance.
module tb_ccff_config_loader;

  logic        clk;
  logic        reset;
  logic        start_w [2];
  logic [7:0]  data_w  [2];
  logic        valid_w [2];
  logic        ready_w [2];
  logic        head_w  [2];
  logic        pclk_w  [2];
  logic        preset_w[2];
  logic        done_w  [2];
  logic        greset_w[2];
  logic        busy_w  [2];
  logic        err_w   [2];
  logic [10:0] bcnt_w  [2];

  ccff_config_loader #(.BITSTREAM_LENGTH(10), .RESET_HOLD_CYCLES(4), .CNT_W(11)) u_dut10 (
    .clk(clk), .reset(reset), .start(start_w[0]), .byte_data(data_w[0]), .byte_valid(valid_w[0]),
    .byte_ready(ready_w[0]), .ccff_head(head_w[0]), .prog_clk(pclk_w[0]), .prog_reset(preset_w[0]),
    .config_done(done_w[0]), .greset(greset_w[0]), .busy(busy_w[0]), .bit_count(bcnt_w[0]), .cfg_err(err_w[0]));

  ccff_config_loader #(.BITSTREAM_LENGTH(1258), .RESET_HOLD_CYCLES(4), .CNT_W(11)) u_dut_full (
    .clk(clk), .reset(reset), .start(start_w[1]), .byte_data(data_w[1]), .byte_valid(valid_w[1]),
    .byte_ready(ready_w[1]), .ccff_head(head_w[1]), .prog_clk(pclk_w[1]), .prog_reset(preset_w[1]),
    .config_done(done_w[1]), .greset(greset_w[1]), .busy(busy_w[1]), .bit_count(bcnt_w[1]), .cfg_err(err_w[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    int         gap1;
    bit         start_hi;
    bit         start_done;
    bit         bad_par;
    int         exp_bits;
    int         exp_accept;
    int         exp_hold;
  } vec_t;

  int         compared;
  int         mismatched;
  int         cur;
  int         len_cur;
  int         pushed;
  int         accepted;
  int         rises;
  int         gap_cnt;
  int         cyc;
  logic       pclk_prev;
  logic [7:0] src_q[$];
  int         gap_q[$];
  logic       exp_q[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] outs(int d);
    return {ready_w[d], head_w[d], pclk_w[d], preset_w[d], done_w[d], greset_w[d], busy_w[d], err_w[d]};
  endfunction

`ifdef CCFF_CONFIG_LOADER_PARITY_EN
  function automatic logic stream_par(int len);
    logic p;
    int   k;
    p = 1'b0;
    k = 0;
    foreach (src_q[j]) begin
      for (int i = 7; i >= 0; i--) begin
        if (k < len) p ^= src_q[j][i];
        k++;
      end
    end
    return p;
  endfunction
`endif

  // One clock: account for the handshake, score prog_clk rises, then drive the source.
  task automatic tick();
    logic       acc;
    logic [7:0] b;
    int         n;
    acc = valid_w[cur] && ready_w[cur];
    b   = data_w[cur];
    @(posedge clk);
    #1;
    cyc++;
    if (acc) begin
      accepted++;
      if (src_q.size() > 0) void'(src_q.pop_front());
      n = (len_cur - pushed > 8) ? 8 : len_cur - pushed;
      for (int i = 0; i < n; i++) exp_q.push_back(b[7-i]);
      pushed += n;
      gap_cnt = (gap_q.size() > 0) ? gap_q.pop_front() : 0;
    end
    if (pclk_w[cur] && !pclk_prev) begin
      rises++;
      if (exp_q.size() == 0) chk("extra_prog_clk_rise", 0, 1);
      else chk("ccff_head_bit", 32'(head_w[cur]), 32'(exp_q.pop_front()));
    end
    pclk_prev    = pclk_w[cur];
    valid_w[cur] = 1'b0;
    if (gap_cnt > 0) begin
      gap_cnt--;
    end else if (src_q.size() > 0) begin
      valid_w[cur] = 1'b1;
      data_w[cur]  = src_q[0];
    end else begin
      valid_w[cur] = 1'b1;
      data_w[cur]  = 8'h3C;
    end
  endtask

  task automatic apply_reset(int d);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_w[i] = 1'b0;
      valid_w[i] = 1'b0;
      data_w[i]  = 8'h00;
    end
    @(posedge clk);
    #1;
    chk("reset_outputs", 32'(outs(d)), 32'h14);
    chk("reset_bit_count", 32'(bcnt_w[d]), 0);
    reset = 1'b0;
  endtask

  task automatic load_two(logic [7:0] b0, logic [7:0] b1, int g1, bit bad_par);
    src_q.delete();
    gap_q.delete();
    src_q.push_back(b0);
    src_q.push_back(b1);
    gap_q.push_back(g1);
`ifdef CCFF_CONFIG_LOADER_PARITY_EN
    src_q.push_back({7'b0, stream_par(10) ^ bad_par});
    gap_q.push_back(0);
`endif
  endtask

  task automatic run_stream(int d, int len, bit start_hi, bit start_done, bit bad_par,
                            int exp_accept, int exp_hold);
    int   t_cd, t_gr, exp_acc;
    bit   finished, hi_done, hi_chk, exp_err;
    logic [10:0] bc_snap;
    cur = d; len_cur = len; pushed = 0; accepted = 0; rises = 0;
    gap_cnt = 0; cyc = 0; pclk_prev = 1'b0;
    exp_q.delete();
    apply_reset(d);
    start_w[d] = 1'b1;
    tick();
    start_w[d] = 1'b0;
    t_cd = -1; t_gr = -1; finished = 0; hi_done = 0; hi_chk = 0; bc_snap = '0;
    while (!finished && cyc < 20 * len + 400) begin
      tick();
      if (hi_chk) begin
        chk("start_in_shift_hi", 32'(bcnt_w[d]), 32'(bc_snap));
        hi_chk = 0;
      end
      if (start_hi && !hi_done && pclk_w[d]) begin
        start_w[d] = 1'b1;
        bc_snap    = bcnt_w[d];
        hi_done    = 1;
        hi_chk     = 1;
      end else begin
        start_w[d] = 1'b0;
      end
      if (t_cd < 0 && done_w[d]) t_cd = cyc;
      if (t_gr < 0 && t_cd >= 0 && !greset_w[d]) t_gr = cyc;
      finished = (t_gr >= 0) || err_w[d];
    end
    start_w[d] = 1'b0;
    chk("completion_within_budget", 32'(finished), 1);
    for (int i = 0; i < 3; i++) tick();
`ifdef CCFF_CONFIG_LOADER_PARITY_EN
    exp_err = bad_par;
    exp_acc = exp_accept + 1;
`else
    exp_err = 0;
    exp_acc = exp_accept;
`endif
    chk("bit_count_final", 32'(bcnt_w[d]), 32'(len));
    chk("prog_clk_rises", 32'(rises), 32'(len));
    chk("bits_left_unshifted", 32'(exp_q.size()), 0);
    chk("bytes_accepted", 32'(accepted), 32'(exp_acc));
    chk("end_state_flags", 32'({err_w[d], done_w[d], greset_w[d], busy_w[d], pclk_w[d]}),
        32'({exp_err, !exp_err, exp_err, 1'b0, 1'b0}));
    if (!exp_err) chk("greset_hold_cycles", 32'(t_gr - t_cd), 32'(exp_hold));
    if (start_done) begin
      start_w[d] = 1'b1;
      tick();
      start_w[d] = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      chk("start_in_done_bit_count", 32'(bcnt_w[d]), 32'(len));
      chk("start_in_done_flags", 32'({done_w[d], greset_w[d], busy_w[d]}), 32'(3'b100));
    end
  endtask

  vec_t vecs[6];

  initial begin
    compared = 0;
    mismatched = 0;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_w[i] = 1'b0;
      valid_w[i] = 1'b0;
      data_w[i]  = 8'h00;
    end
    vecs[0] = '{8'hA5, 8'hC0, 0, 0, 0, 0, 10, 2, 4};
    vecs[1] = '{8'hA5, 8'hC0, 7, 0, 0, 0, 10, 2, 4};
    vecs[2] = '{8'hA5, 8'hC0, 0, 1, 1, 0, 10, 2, 4};
    vecs[3] = '{8'hFF, 8'h40, 3, 0, 0, 0, 10, 2, 4};
    vecs[4] = '{8'hA5, 8'hC0, 1, 0, 0, 1, 10, 2, 4};
    vecs[5] = '{8'h3C, 8'h00, 0, 0, 1, 0, 10, 2, 4};

    foreach (vecs[v]) begin
      load_two(vecs[v].b0, vecs[v].b1, vecs[v].gap1, vecs[v].bad_par);
      run_stream(0, vecs[v].exp_bits, vecs[v].start_hi, vecs[v].start_done, vecs[v].bad_par,
                 vecs[v].exp_accept, vecs[v].exp_hold);
    end

    // Reset after bit 5 must clear outputs without waiting for a clock edge, then reprogram from bit 0.
    load_two(8'hA5, 8'hC0, 0, 0);
    cur = 0; len_cur = 10; pushed = 0; accepted = 0; rises = 0; gap_cnt = 0; cyc = 0;
    pclk_prev = 1'b0;
    exp_q.delete();
    apply_reset(0);
    start_w[0] = 1'b1;
    tick();
    start_w[0] = 1'b0;
    while (rises < 5 && cyc < 200) tick();
    chk("reached_bit5", 32'(rises), 5);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_outputs", 32'(outs(0)), 32'h14);
    chk("async_reset_bit_count", 32'(bcnt_w[0]), 0);
    load_two(8'hA5, 8'hC0, 0, 0);
    run_stream(0, 10, 0, 0, 0, 2, 4);

    // Full-length stream: the 158th byte supplies only its two MSBs.
    src_q.delete();
    gap_q.delete();
    for (int i = 0; i < 158; i++) begin
      src_q.push_back(8'($urandom_range(0, 255)));
      if (i > 0) gap_q.push_back(($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 5)) : 0);
    end
`ifdef CCFF_CONFIG_LOADER_PARITY_EN
    src_q.push_back({7'b0, stream_par(1258)});
    gap_q.push_back(0);
`endif
    run_stream(1, 1258, 0, 0, 0, 158, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
